mul_div_unit: RTL and testbench
===============================

# mul_div_unit

Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers. It sits beside the ALU in the execute stage and handles MULT/MULTU/DIV/DIVU/MTHI/MTLO, which the single-cycle ALU cannot. Multiplies go through an internal pipeline; divides run an iterative radix-2 restoring algorithm. A valid/ready handshake, busy flag and flush input let the pipeline stall on HI/LO hazards and abort on exceptions.

## Interface
Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits; ≥ 8, even.
- MUL_STAGES, 2, multiply latency in cycles from accept to HI/LO write; ≥ 1.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- resetn  in  1  synchronous, active-low reset.
- op_valid  in  1  request present.
- op_ready  out  1  unit can accept; combinational, = (state == IDLE).
- op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6/7 accepted, no effect.
- src1  in  WIDTH  rs value (dividend / multiplicand / MTHI-MTLO data).
- src2  in  WIDTH  rt value (divisor / multiplier).
- flush  in  1  abort in-flight operation and drop any same-cycle request.
- busy  out  1  = (state != IDLE).
- done  out  1  one-cycle pulse, high in the cycle HI/LO first show a new MUL/DIV result.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

## Operation
- Accept = op_valid && op_ready && !flush, sampled at an edge (E0).
- States: IDLE, MUL, DIV, FIX.
  - IDLE → MUL on accepted MULT/MULTU.
  - IDLE → DIV on accepted DIV/DIVU.
  - MTHI/MTLO write hi/lo at E0 and stay IDLE; no done.
  - MUL: counter counts MUL_STAGES cycles. The 2·WIDTH product is written {hi,lo} at E(MUL_STAGES), then → IDLE.
    - MULT: signed × signed.
    - MULTU: unsigned × unsigned.
  - DIV: operands are latched at E0.
    - Signed ops use magnitudes; operand signs are recorded at E0.
    - One restoring iteration per edge, E1..E(WIDTH), then → FIX.
  - FIX: apply signs and write at E(WIDTH+1), then → IDLE.
    - lo = quotient; sign = s1 ^ s2.
    - hi = remainder; sign = s1.
- Divide by zero: lo = all ones, hi = src1 as latched, for both DIV and DIVU. Latency is unchanged. No exception.
- Signed overflow (MIN / −1): lo = MIN, hi = 0, arising naturally from the WIDTH-bit magnitude path.
- flush in any non-IDLE state: → IDLE at that edge; hi/lo unchanged; no done. Flush on the write edge blocks the write.
- Flush while IDLE: MTHI/MTLO on that edge is dropped.
- hi/lo outputs always reflect the registers. Consumers must stall while busy.

## Timing
- Reset at an edge with resetn = 0, in any state including mid-divide:
  - state = IDLE, hi = 0, lo = 0, done = 0, counters = 0.
  - busy = 0 and op_ready = 1 in the following cycle.
- Multiply: done high in the cycle after E(MUL_STAGES), which is the first cycle hi/lo hold the product.
- Divide: done high in the cycle after E(WIDTH+1), i.e. WIDTH+1 edges after accept (33 for WIDTH = 32).
- op_ready is high in the done cycle, so back-to-back operations are allowed. A new accept in the done cycle does not affect the visible hi/lo until its own write.
- MTHI/MTLO: value visible the cycle after E0.
- Internal datapath widths:
  - Multiply product: 2·WIDTH.
  - Divider partial remainder: WIDTH+1 bits, unsigned.
  - Quotient register: WIDTH bits.
- Counter width: clog2(WIDTH+1) bits; never wraps.

## Test plan
WIDTH = 32, MUL_STAGES = 2.
- MULT 0xFFFFFFFF × 0x00000002 → hi = FFFFFFFF, lo = FFFFFFFE, done in 3rd cycle after accept. MULTU with the same operands → hi = 00000001, lo = FFFFFFFE.
- DIV −7/2 (FFFFFFF9, 00000002) → lo = FFFFFFFD, hi = FFFFFFFF, done exactly 33 edges after accept. DIVU 7/2 → lo = 3, hi = 1.
- DIV 80000000 / FFFFFFFF → lo = 80000000, hi = 0. DIVU 00001234 / 0 → lo = FFFFFFFF, hi = 00001234.
- MTHI A5A5A5A5 then MTLO 5A5A5A5A on consecutive cycles → hi/lo updated 1 cycle after each, no done. MTHI while busy → op_ready = 0, not accepted.
- DIV in flight, flush on iteration 10 → no done, hi/lo keep their prior values, op_ready = 1 next cycle. A request in the flush cycle is dropped.
- resetn = 0 mid-divide → hi = lo = 0, busy = 0. Back-to-back MULT issued in the done cycle → second result correct, two done pulses.

Source files
------------

// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Multiply result lands after MUL_STAGES cycles; divide is radix-2 restoring.
module mul_div_unit #(
  parameter int WIDTH      = 32,
  parameter int MUL_STAGES = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int PW = 2 * WIDTH;

  localparam logic [CW-1:0] MUL_LAST = CW'(MUL_STAGES);
  localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX
  } state_e;

  state_e state_q, state_d;

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;
  logic [PW-1:0]    prod_q, prod_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic             dz_q, dz_d;

  logic             accept;
  logic             is_mul;
  logic             is_div;
  logic             msign;
  logic             s1;
  logic             s2;
  logic [PW-1:0]    a_ext;
  logic [PW-1:0]    b_ext;
  logic [PW-1:0]    prod_full;
  logic [WIDTH-1:0] mag1;
  logic [WIDTH-1:0] mag2;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;
  logic             ge;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  assign op_ready = (state_q == S_IDLE);
  assign busy     = ~op_ready;
  assign done     = done_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

  assign accept = op_valid & op_ready & ~flush;
  assign is_mul = (op == OP_MULT) | (op == OP_MULTU);
  assign is_div = (op == OP_DIV) | (op == OP_DIVU);
  assign msign  = (op == OP_MULT);

  assign a_ext = {{WIDTH{msign & src1[WIDTH-1]}}, src1};
  assign b_ext = {{WIDTH{msign & src2[WIDTH-1]}}, src2};
  assign prod_full = a_ext * b_ext;

  assign s1   = (op == OP_DIV) & src1[WIDTH-1];
  assign s2   = (op == OP_DIV) & src2[WIDTH-1];
  assign mag1 = s1 ? -src1 : src1;
  assign mag2 = s2 ? -src2 : src2;

  // Borrow out of the (WIDTH+1)-bit trial subtract decides the quotient bit.
  assign rem_sh = {rem_q, quo_q[WIDTH-1]};
  assign diff   = rem_sh - {1'b0, dvs_q};
  assign ge     = ~diff[WIDTH];

  assign q_fix = (s1_q ^ s2_q) ? -quo_q : quo_q;
  assign r_fix = s1_q ? -rem_q : rem_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    prod_d  = prod_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    dvd_d   = dvd_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    dz_d    = dz_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          unique case (1'b1)
            is_mul: begin
              prod_d  = prod_full;
              cnt_d   = CNT_ONE;
              state_d = S_MUL;
            end
            is_div: begin
              rem_d   = '0;
              quo_d   = mag1;
              dvs_d   = mag2;
              dvd_d   = src1;
              s1_d    = s1;
              s2_d    = s2;
              dz_d    = (src2 == '0);
              cnt_d   = '0;
              state_d = S_DIV;
            end
            (op == OP_MTHI): hi_d = src1;
            (op == OP_MTLO): lo_d = src1;
            default: ;
          endcase
        end
      end
      S_MUL: begin
        if (flush) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (cnt_q == MUL_LAST) begin
          hi_d    = prod_q[PW-1:WIDTH];
          lo_d    = prod_q[WIDTH-1:0];
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_DIV: begin
        if (flush) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          rem_d = ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], ge};
          if (cnt_q == DIV_LAST) begin
            cnt_d   = '0;
            state_d = S_FIX;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!flush) begin
          // Divide by zero reports the raw dividend, not the sign-fixed one.
          hi_d   = dz_q ? dvd_q : r_fix;
          lo_d   = dz_q ? '1 : q_fix;
          done_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      prod_q  <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      dvd_q   <= '0;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      prod_q  <= prod_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      dvd_q   <= dvd_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      dz_q    <= dz_d;
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: arithmetic reference model plus directed
// vectors with hand-computed HI/LO results and latencies.
module tb_mul_div_unit;

  localparam int W  = 32;
  localparam int MS = 2;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         op_valid = 1'b0;
  logic         flush = 1'b0;
  logic [2:0]   op = '0;
  logic [W-1:0] src1 = '0;
  logic [W-1:0] src2 = '0;
  logic         op_ready;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  mul_div_unit #(
    .WIDTH(W),
    .MUL_STAGES(MS)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .op_valid(op_valid),
    .op_ready(op_ready),
    .op(op),
    .src1(src1),
    .src2(src2),
    .flush(flush),
    .busy(busy),
    .done(done),
    .hi(hi),
    .lo(lo)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference arithmetic: {hi, lo} for a MUL/DIV request.
  function automatic logic [63:0] model_res(input logic [2:0] o,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa;
    longint sb;
    sa = $signed(a);
    sb = $signed(b);
    case (o)
      3'd0: return sa * sb;
      3'd1: return {32'd0, a} * {32'd0, b};
      3'd2: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {32'(sa % sb), 32'(sa / sb)};
      end
      3'd3: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: return 64'd0;
    endcase
  endfunction

  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;
  logic [W-1:0] p_hi = '0;
  logic [W-1:0] p_lo = '0;
  int           m_left = 0;
  bit           m_pend = 1'b0;
  bit           m_done = 1'b0;

  always @(posedge clk) begin
    m_done = 1'b0;
    if (!resetn) begin
      m_hi   = '0;
      m_lo   = '0;
      m_pend = 1'b0;
      m_left = 0;
    end else if (m_pend) begin
      if (flush) begin
        m_pend = 1'b0;
      end else begin
        m_left--;
        if (m_left == 0) begin
          m_hi   = p_hi;
          m_lo   = p_lo;
          m_done = 1'b1;
          m_pend = 1'b0;
        end
      end
    end else if (op_valid && !flush) begin
      case (op)
        3'd0, 3'd1: begin
          {p_hi, p_lo} = model_res(op, src1, src2);
          m_left = MS;
          m_pend = 1'b1;
        end
        3'd2, 3'd3: begin
          {p_hi, p_lo} = model_res(op, src1, src2);
          m_left = W + 1;
          m_pend = 1'b1;
        end
        3'd4: m_hi = src1;
        3'd5: m_lo = src1;
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("hi", hi, m_hi);
      check("lo", lo, m_lo);
      check("done", done, m_done);
      check("busy", busy, m_pend);
      check("op_ready", op_ready, !m_pend);
    end
  end

  task automatic issue(input logic [2:0] o,
                       input logic [31:0] a,
                       input logic [31:0] b);
    #1;
    op       = o;
    src1     = a;
    src2     = b;
    op_valid = 1'b1;
  endtask

  task automatic release_in();
    #1;
    op_valid = 1'b0;
    flush    = 1'b0;
    op       = '0;
    src1     = '0;
    src2     = '0;
  endtask

  // Returns at the negedge where done is first seen.
  task automatic run_op(input logic [2:0] o,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input int lat,
                        input logic [31:0] eh,
                        input logic [31:0] el);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    issue(o, a, b);
    while (n < 60 && !seen) begin
      @(negedge clk);
      n++;
      seen = done;
      if (n == 1) release_in();
    end
    check("done_timeout", seen, 1);
    check("latency", n - 1, lat);
    check("res_hi", hi, eh);
    check("res_lo", lo, el);
  endtask

  task automatic flush_op(input logic [2:0] o,
                          input logic [31:0] a,
                          input logic [31:0] b,
                          input int fn,
                          input logic [31:0] eh,
                          input logic [31:0] el);
    issue(o, a, b);
    for (int n = 1; n <= fn + 1; n++) begin
      @(negedge clk);
      if (n == fn + 1) begin
        check("fl_busy", busy, 0);
        check("fl_ready", op_ready, 1);
        check("fl_done", done, 0);
        check("fl_hi", hi, eh);
        check("fl_lo", lo, el);
        release_in();
      end else if (n == fn) begin
        #1;
        flush    = 1'b1;
        op_valid = 1'b1;
        op       = 3'd4;
        src1     = 32'hDEAD_BEEF;
      end else if (n == 1) begin
        release_in();
      end
    end
  endtask

  task automatic idle(input int k);
    repeat (k) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    #1 chk_en = 1'b1;
    @(negedge clk);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", op_ready, 1);
    check("rst_done", done, 0);
    #1 resetn = 1'b1;
    idle(1);

    run_op(3'd0, 32'hFFFF_FFFF, 32'h2, 2, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    idle(1);
    run_op(3'd1, 32'hFFFF_FFFF, 32'h2, 2, 32'h0000_0001, 32'hFFFF_FFFE);
    idle(1);
    run_op(3'd2, 32'hFFFF_FFF9, 32'h2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    idle(1);
    run_op(3'd3, 32'h7, 32'h2, 33, 32'h1, 32'h3);
    idle(1);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h0, 32'h8000_0000);
    idle(1);
    run_op(3'd3, 32'h0000_1234, 32'h0, 33, 32'h0000_1234, 32'hFFFF_FFFF);
    idle(1);
    run_op(3'd2, 32'hFFFF_FFF9, 32'h0, 33, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
    idle(1);
    run_op(3'd2, 32'h7, 32'hFFFF_FFFE, 33, 32'h1, 32'hFFFF_FFFD);
    idle(1);
    run_op(3'd2, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 33, 32'hFFFF_FFFF, 32'h3);
    idle(1);

    issue(3'd4, 32'hA5A5_A5A5, 32'h0);
    @(negedge clk);
    check("mthi_hi", hi, 32'hA5A5_A5A5);
    check("mthi_done", done, 0);
    issue(3'd5, 32'h5A5A_5A5A, 32'h0);
    @(negedge clk);
    check("mtlo_lo", lo, 32'h5A5A_5A5A);
    check("mtlo_done", done, 0);
    release_in();
    idle(1);

    issue(3'd0, 32'h0001_0000, 32'h0001_0000);
    @(negedge clk);
    check("busy_ready", op_ready, 0);
    issue(3'd4, 32'h0BAD_0BAD, 32'h0);
    @(negedge clk);
    release_in();
    @(negedge clk);
    check("busy_done", done, 1);
    check("busy_hi", hi, 32'h1);
    check("busy_lo", lo, 32'h0);
    idle(1);

    flush_op(3'd2, 32'd100, 32'd7, 10, 32'h1, 32'h0);
    idle(1);
    flush_op(3'd0, 32'd5, 32'd5, 2, 32'h1, 32'h0);
    idle(1);

    #1;
    op       = 3'd5;
    src1     = 32'd77;
    op_valid = 1'b1;
    flush    = 1'b1;
    @(negedge clk);
    check("idle_flush_lo", lo, 32'h0);
    check("idle_flush_busy", busy, 0);
    release_in();
    idle(1);

    issue(3'd6, 32'd123, 32'd4);
    @(negedge clk);
    check("op6_busy", busy, 0);
    check("op6_hi", hi, 32'h1);
    release_in();
    idle(1);

    issue(3'd3, 32'd100, 32'd3);
    @(negedge clk);
    release_in();
    idle(4);
    #1 resetn = 1'b0;
    @(negedge clk);
    check("mid_rst_hi", hi, 0);
    check("mid_rst_lo", lo, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ready", op_ready, 1);
    #1 resetn = 1'b1;
    idle(1);

    run_op(3'd0, 32'h3, 32'hFFFF_FFFC, 2, 32'hFFFF_FFFF, 32'hFFFF_FFF4);
    run_op(3'd0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 2,
           32'h3FFF_FFFF, 32'h0000_0001);
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
